// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with a sticky sideband and a synchronous flush.
// Latency: one cycle from accept to dn_data. A continuous dn_ready sustains one transfer per cycle.
// Backpressure: up_ready falls only when both entries are held. All outputs come straight from flops.
module pipe_skid_reg #(
  parameter int              DW      = 128,
  parameter int              SW      = 1,
  parameter logic [DW-1:0]   NOP_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  input  logic [SW-1:0] up_sticky,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data,
  output logic [SW-1:0] dn_sticky,
  output logic [1:0]    occ
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic [SW-1:0] sticky_q, sticky_d;
  logic          up_ready_q;
  logic          dn_valid_q;
  logic          accept;
  logic          pop;

  // The handshake qualifiers use the registered flags, so up_data is ignored when up_valid is low and dn_ready is ignored when the stage is empty.
  assign accept = up_valid & up_ready_q;
  assign pop    = dn_valid_q & dn_ready;

  // Next-state and datapath selection. Flush overrides everything, including an accept in the same cycle.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    sticky_d = sticky_q;
    if (flush) begin
      state_d  = EMPTY;
      main_d   = NOP_VAL;
      skid_d   = NOP_VAL;
      sticky_d = '0;
    end else begin
      if (accept) begin
        sticky_d = up_sticky;
      end
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = up_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = up_data;
          end else if (accept) begin
            skid_d  = up_data;
            state_d = TWO;
          end else if (pop) begin
            main_d  = NOP_VAL;
            state_d = EMPTY;
          end
        end
        TWO: begin
          // up_ready is low here, so a pop is the only possible event.
          if (pop) begin
            main_d  = skid_q;
            skid_d  = NOP_VAL;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

  // State, payload and handshake flags. The flags are precomputed from the next state so no output passes through logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= NOP_VAL;
      skid_q     <= NOP_VAL;
      sticky_q   <= '0;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      sticky_q   <= sticky_d;
      up_ready_q <= (state_d != TWO);
      dn_valid_q <= (state_d != EMPTY);
    end
  end

  assign up_ready  = up_ready_q;
  assign dn_valid  = dn_valid_q;
  assign dn_data   = main_q;
  assign dn_sticky = sticky_q;
  assign occ       = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg at DW=8, SW=3 with a non-zero NOP value.
// Directed scenarios first, then a random-handshake run against a reference queue.
// Inputs change 1 time unit after each rising edge; outputs are compared at that time.
module tb_pipe_skid_reg;

  localparam int         DW  = 8;
  localparam int         SW  = 3;
  localparam logic [7:0] NOP = 8'h5A;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] up_data;
  logic [SW-1:0] up_sticky;
  logic          dn_valid;
  logic          dn_ready;
  logic [DW-1:0] dn_data;
  logic [SW-1:0] dn_sticky;
  logic [1:0]    occ;

  int total  = 0;
  int passed = 0;

  // Reference model: FIFO of accepted payloads plus the last accepted sideband.
  logic [DW-1:0] mq[$];
  logic [SW-1:0] m_sticky = '0;

  pipe_skid_reg #(.DW(DW), .SW(SW), .NOP_VAL(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_sticky(up_sticky),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data), .dn_sticky(dn_sticky),
    .occ(occ)
  );

  always #5 clk = ~clk;

  // Advance one clock; the scoreboard pushes on accept and pops on pop, using its own occupancy.
  task automatic tick();
    bit acc, pp;
    logic [DW-1:0] tmp;
    acc = up_valid && (mq.size() < 2);
    pp  = (mq.size() > 0) && dn_ready;
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_sticky = '0;
    end else begin
      if (pp) tmp = mq.pop_front();
      if (acc) begin
        mq.push_back(up_data);
        m_sticky = up_sticky;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    total++; if (up_ready !== 1'b1) $display("FAIL reset_up_ready got %b want 1", up_ready); else passed++;
    total++; if (dn_valid !== 1'b0) $display("FAIL reset_dn_valid got %b want 0", dn_valid); else passed++;
    total++; if (occ !== 2'd0) $display("FAIL reset_occ got %0d want 0", occ); else passed++;
    total++; if (dn_data !== NOP) $display("FAIL reset_dn_data got %h want %h", dn_data, NOP); else passed++;
    total++; if (dn_sticky !== 3'd0) $display("FAIL reset_dn_sticky got %h want 0", dn_sticky); else passed++;
  endtask

  task automatic test_streaming();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_valid = 1'b1; up_data = vals[i];
      tick();
      total++; if (dn_data !== vals[i]) $display("FAIL stream_data[%0d] got %h want %h", i, dn_data, vals[i]); else passed++;
      total++; if (dn_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", i, dn_valid); else passed++;
      total++; if (up_ready !== 1'b1) $display("FAIL stream_up_ready[%0d] got %b want 1", i, up_ready); else passed++;
      total++; if (occ > 2'd1) $display("FAIL stream_occ[%0d] got %0d want <=1", i, occ); else passed++;
    end
    up_valid = 1'b0;
    tick();
    total++; if (dn_valid !== 1'b0) $display("FAIL stream_drain_valid got %b want 0", dn_valid); else passed++;
    total++; if (dn_data !== NOP) $display("FAIL stream_drain_data got %h want %h", dn_data, NOP); else passed++;
  endtask

  task automatic test_skid();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 8'h0A; tick();
    up_data = 8'h0B; tick();
    total++; if (occ !== 2'd2) $display("FAIL skid_occ got %0d want 2", occ); else passed++;
    total++; if (up_ready !== 1'b0) $display("FAIL skid_up_ready got %b want 0", up_ready); else passed++;
    total++; if (dn_data !== 8'h0A) $display("FAIL skid_head got %h want 0a", dn_data); else passed++;
    // Offer while full: must not be taken.
    up_data = 8'h77; tick();
    total++; if (occ !== 2'd2) $display("FAIL skid_full_occ got %0d want 2", occ); else passed++;
    total++; if (dn_data !== 8'h0A) $display("FAIL skid_full_head got %h want 0a", dn_data); else passed++;
    up_valid = 1'b0; dn_ready = 1'b1;
    tick();
    total++; if (dn_data !== 8'h0B) $display("FAIL skid_second got %h want 0b", dn_data); else passed++;
    total++; if (occ !== 2'd1) $display("FAIL skid_second_occ got %0d want 1", occ); else passed++;
    tick();
    total++; if (dn_valid !== 1'b0) $display("FAIL skid_empty_valid got %b want 0", dn_valid); else passed++;
    total++; if (dn_data !== NOP) $display("FAIL skid_empty_data got %h want %h", dn_data, NOP); else passed++;
  endtask

  task automatic test_flush();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_sticky = 3'd5; up_data = 8'h01; tick();
    up_data = 8'h02; tick();
    total++; if (occ !== 2'd2) $display("FAIL flush_pre_occ got %0d want 2", occ); else passed++;
    flush = 1'b1; up_data = 8'h0C;
    tick();
    flush = 1'b0; up_valid = 1'b0;
    total++; if (occ !== 2'd0) $display("FAIL flush_occ got %0d want 0", occ); else passed++;
    total++; if (dn_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", dn_valid); else passed++;
    total++; if (dn_data !== NOP) $display("FAIL flush_data got %h want %h", dn_data, NOP); else passed++;
    total++; if (dn_sticky !== 3'd0) $display("FAIL flush_sticky got %h want 0", dn_sticky); else passed++;
    dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (dn_valid !== 1'b0 || dn_data === 8'h0C) $display("FAIL flush_leak[%0d] got valid %b data %h want 0/%h", i, dn_valid, dn_data, NOP); else passed++;
    end
  endtask

  task automatic test_sticky();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 8'h03; up_sticky = 3'd1; tick();
    up_valid = 1'b0; up_sticky = 3'b110;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (dn_sticky !== 3'd1) $display("FAIL sticky_stall[%0d] got %h want 1", i, dn_sticky); else passed++;
    end
    dn_ready = 1'b1; tick();
    total++; if (occ !== 2'd0) $display("FAIL sticky_pop_occ got %0d want 0", occ); else passed++;
    total++; if (dn_sticky !== 3'd1) $display("FAIL sticky_after_pop got %h want 1", dn_sticky); else passed++;
    tick();
    total++; if (dn_sticky !== 3'd1) $display("FAIL sticky_bubble got %h want 1", dn_sticky); else passed++;
  endtask

  task automatic test_reset_mid();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 8'h06; up_sticky = 3'd7; tick();
    up_data = 8'h07; tick();
    up_valid = 1'b0;
    total++; if (occ !== 2'd2) $display("FAIL rstmid_pre_occ got %0d want 2", occ); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (up_ready !== 1'b1) $display("FAIL rstmid_up_ready got %b want 1", up_ready); else passed++;
    total++; if (dn_valid !== 1'b0) $display("FAIL rstmid_dn_valid got %b want 0", dn_valid); else passed++;
    total++; if (occ !== 2'd0) $display("FAIL rstmid_occ got %0d want 0", occ); else passed++;
    total++; if (dn_data !== NOP) $display("FAIL rstmid_data got %h want %h", dn_data, NOP); else passed++;
    total++; if (dn_sticky !== 3'd0) $display("FAIL rstmid_sticky got %h want 0", dn_sticky); else passed++;
    #1 rst_n = 1'b1;
    mq.delete(); m_sticky = '0;
    up_valid = 1'b1; up_data = 8'h05; up_sticky = 3'd2;
    tick();
    up_valid = 1'b0;
    total++; if (dn_data !== 8'h05) $display("FAIL rstmid_accept_data got %h want 05", dn_data); else passed++;
    total++; if (occ !== 2'd1) $display("FAIL rstmid_accept_occ got %0d want 1", occ); else passed++;
    dn_ready = 1'b1; tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 10000; c++) begin
      up_valid  = ($urandom_range(0, 9) < 6);
      up_data   = DW'($urandom);
      up_sticky = SW'($urandom);
      dn_ready  = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 199) == 0);
      total++; if (up_ready !== (mq.size() < 2)) begin bad++; if (bad < 10) $display("FAIL rand_up_ready@%0d got %b want %b", c, up_ready, mq.size() < 2); end else passed++;
      total++; if (occ !== 2'(mq.size())) begin bad++; if (bad < 10) $display("FAIL rand_occ@%0d got %0d want %0d", c, occ, mq.size()); end else passed++;
      total++; if (dn_valid !== (mq.size() > 0)) begin bad++; if (bad < 10) $display("FAIL rand_valid@%0d got %b want %b", c, dn_valid, mq.size() > 0); end else passed++;
      total++; if (dn_data !== ((mq.size() > 0) ? mq[0] : NOP)) begin bad++; if (bad < 10) $display("FAIL rand_data@%0d got %h want %h", c, dn_data, (mq.size() > 0) ? mq[0] : NOP); end else passed++;
      total++; if (dn_sticky !== m_sticky) begin bad++; if (bad < 10) $display("FAIL rand_sticky@%0d got %h want %h", c, dn_sticky, m_sticky); end else passed++;
      tick();
    end
    flush = 1'b0; up_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; up_sticky = '0; dn_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_streaming();
    test_skid();
    test_flush();
    test_sticky();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DW, default 128, meaning payload width in bits.
REQ-002 SHALL have parameter SW, default 1, meaning sticky sideband width in bits.
REQ-003 SHALL have parameter NOP_VAL, DW bits wide, default all-zero, meaning the payload value driven when no valid entry is presented.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-007 SHALL have port up_valid  input  1  upstream entry offered.
REQ-008 SHALL have port up_ready  output  1  stage can accept an entry.
REQ-009 SHALL have port up_data  input  DW  upstream payload.
REQ-010 SHALL have port up_sticky  input  SW  upstream sideband, captured only on accept.
REQ-011 SHALL have port dn_valid  output  1  head entry presented downstream.
REQ-012 SHALL have port dn_ready  input  1  downstream consumes the head.
REQ-013 SHALL have port dn_data  output  DW  head payload.
REQ-014 SHALL have port dn_sticky  output  SW  last accepted sideband.
REQ-015 SHALL have port occ  output  2  entry count, 0 to 2.

Function
REQ-016 SHALL define accept as up_valid&up_ready and pop as dn_valid&dn_ready, both sampled on the rising edge of clk.
REQ-017 SHALL hold a main register and a skid register, and SHALL use states EMPTY (occ=0), ONE (occ=1) and TWO (occ=2).
REQ-018 SHALL drive all outputs directly from flops: up_ready=(state!=TWO), dn_valid=(state!=EMPTY), dn_data=main.
REQ-019 SHALL, in EMPTY, on accept, load main<=up_data and go to ONE.
REQ-020 SHALL, in ONE, on accept together with pop, load main<=up_data and stay in ONE.
REQ-021 SHALL, in ONE, on accept without pop, load skid<=up_data and go to TWO, leaving main unchanged.
REQ-022 SHALL, in ONE, on pop without accept, load main<=NOP_VAL and go to EMPTY.
REQ-023 SHALL, in TWO, on pop, load main<=skid and skid<=NOP_VAL, and go to ONE; no accept is possible in TWO.
REQ-024 SHALL, when neither accept nor pop occurs, hold all registers and state.
REQ-025 SHALL take one cycle from accept to the entry appearing on dn_data, and SHALL sustain one transfer per cycle while dn_ready is continuously 1.
REQ-026 SHALL deliver entries in acceptance order, with no loss and no duplication.
REQ-027 SHALL update dn_sticky<=up_sticky only on accept, and SHALL hold dn_sticky during stall (dn_ready=0), empty bubbles and pops.
REQ-028 SHALL give flush the highest synchronous priority: state<=EMPTY, main<=NOP_VAL, skid<=NOP_VAL, dn_sticky<=0; any accept in the flush cycle is discarded.
REQ-029 SHALL keep dn_data equal to NOP_VAL whenever dn_valid=0.
REQ-030 SHALL ignore up_data and up_sticky when up_valid=0, and SHALL ignore dn_ready when dn_valid=0.

Reset
REQ-031 SHALL, while rst_n=0 and independent of clk, force state=EMPTY, main=NOP_VAL, skid=NOP_VAL and dn_sticky=0, giving outputs up_ready=1, dn_valid=0, occ=0.
REQ-032 SHALL, when reset is asserted in TWO, drop both entries, and SHALL accept normally on the first clk edge after release.

Verification
REQ-033 SHALL check streaming: dn_ready=1 and values 0x11, 0x22, 0x33 offered on consecutive cycles -> dn_data shows 0x11, 0x22, 0x33 one cycle later each, up_ready stays 1, occ stays at 1 or below.
REQ-034 SHALL check the skid path: dn_ready=0, accept 0xA then 0xB -> occ=2, up_ready=0, dn_data=0xA; then dn_ready=1 -> 0xA, then 0xB, then dn_valid=0 with dn_data=NOP_VAL.
REQ-035 SHALL check flush: occ=2 with flush=1 and up_valid=1 (0xC) in the same cycle -> next cycle occ=0, dn_valid=0, 0xC never appears downstream.
REQ-036 SHALL check the sticky sideband: accept with up_sticky=1, then up_valid=0 for 3 cycles with dn_ready=0 -> dn_sticky stays 1; after a pop to EMPTY, dn_sticky is still 1.
REQ-037 SHALL check reset mid-operation: rst_n pulsed low in TWO between edges -> outputs clear immediately, then accept 0x5 -> dn_data=0x5 on the next cycle.
REQ-038 SHALL check against a random-handshake reference queue for 10000 cycles with DW=8 and SW=3 -> order preserved, occ matches the model, and no accept happens while up_ready=0.
